spi_slave_shift: RTL and testbench
==================================

SPI_SLAVE_SHIFT -- requirements
Module: spi_slave_shift

Interface
REQ-001 Parameter CHAR_LEN, default 8, shall set the word length in bits (legal 2..32).
REQ-002 Parameter LSB_FIRST, default 0, shall select LSB-first shifting when 1; 0 is MSB-first.
REQ-003 clk  in  1  single block clock; all state shall be in this domain.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 sclk_pad_i  in  1  SPI clock from the master, asynchronous to clk.
REQ-006 ss_pad_i  in  1  slave select from the master, active-low.
REQ-007 mosi_pad_i  in  1  serial data from the master.
REQ-008 miso_pad_o  out  1  serial data to the master.
REQ-009 rx_data_o  out  CHAR_LEN  received word.
REQ-010 rx_valid_o  out  1  rx_data_o holds an unconsumed word.
REQ-011 rx_ready_i  in  1  consumer accepts rx_data_o.
REQ-012 tx_data_i  in  CHAR_LEN  word to transmit.
REQ-013 tx_load_i  in  1  one-cycle strobe that captures tx_data_i into the tx holding register.
REQ-014 busy_o  out  1  high while the block is in state ACTIVE.
REQ-015 ovr_o  out  1  sticky overrun flag; present only with SPI_SLV_OVR_EN.

Function
REQ-016 sclk_pad_i, ss_pad_i and mosi_pad_i shall each pass through a 2-flop synchronizer; edges shall be detected between the second and third flop stages.
REQ-017 SPI mode 0 is fixed: mosi shall be sampled on a detected sclk rising edge, and miso shall be updated on a detected sclk falling edge.
REQ-018 FSM states: IDLE and ACTIVE. IDLE->ACTIVE on a synchronized ss falling edge; ACTIVE->IDLE on a synchronized ss rising edge.
REQ-019 On IDLE->ACTIVE, the shift register shall load from the tx holding register, the bit counter shall clear, and miso_pad_o shall present the first tx bit in the same cycle.
REQ-020 Each rising edge in ACTIVE shall shift in one mosi bit and increment the bit counter.
REQ-021 On the CHAR_LEN-th rising edge, the counter shall wrap to 0, and the received word shall reach rx_data_o with rx_valid_o=1 on the next clk cycle.
REQ-022 The falling edge that follows a wrap shall reload the shift register from the tx holding register, so back-to-back words are supported within one ss-low period.
REQ-023 rx_valid_o shall hold, with rx_data_o stable, until a cycle with rx_ready_i=1; it shall clear in the following cycle unless a new word loads in that same cycle.
REQ-024 If a word completes while rx_valid_o=1 and rx_ready_i=0, the new word shall be dropped and the old word kept.
REQ-025 If a word completes in the same cycle as a handshake, the new word shall load and rx_valid_o shall stay 1.
REQ-026 ss rising edge mid-word: the partial word shall be discarded, the counter cleared, and no rx_valid_o pulse generated.
REQ-027 tx_load_i shall be honoured in any state; the new value takes effect at the next reload point (REQ-019/022).
REQ-028 Operation is guaranteed for sclk high and low phases each >= 4 clk periods.

Reset
REQ-029 rst_n low shall asynchronously force: state IDLE, counter 0, synchronizers to ss=1 and sclk=0, shift and holding registers 0, rx_data_o 0, rx_valid_o 0, miso_pad_o 0, busy_o 0, ovr_o 0.

Configuration
REQ-030 With SPI_SLV_OVR_EN defined, ovr_o shall exist, set on every REQ-024 drop, and clear only on reset or on a rx handshake.
REQ-031 Without SPI_SLV_OVR_EN, ovr_o and its logic shall be absent; drop behaviour is unchanged.

Structure
REQ-032 Package spi_slv_pkg shall hold the FSM state enum, the CHAR_LEN default constant and the synchronizer depth constant.
REQ-033 Sub-module spi_slv_sync (2-flop synchronizer plus rise/fall detect) shall be instantiated three times.

Verification
REQ-034 Single word: load 0xA5, MSB-first, master sends 0x3C -> rx_data_o=0x3C with a single-cycle rx_valid_o/ready handshake, and the master receives 0xA5.
REQ-035 LSB_FIRST=1, CHAR_LEN=16, master sends 0x1234 -> rx_data_o=0x1234; the first miso bit equals tx bit 0.
REQ-036 Back-to-back 0x11 then 0x22 in one ss-low period, ready held 0 -> rx_data_o stays 0x11 and ovr_o=1 (macro on).
REQ-037 ss deasserted after 5 of 8 bits, then a full word 0x7E -> only 0x7E is delivered.
REQ-038 rst_n asserted mid-word -> all outputs at reset values immediately; the next full transfer 0x81 is received correctly.
REQ-039 Word completes in the handshake cycle -> rx_valid_o stays 1 and rx_data_o updates to the new word.

Source files
------------

// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave shifter.
// Holds the FSM state enum, word-length default and synchronizer depth.
package spi_slv_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int CHAR_LEN_DEF = 8;
   localparam int SYNC_DEPTH   = 2;

endpackage

// File: rtl/spi_slv_sync.sv
// Pad synchronizer with edge detect between the last sync stage
// and one extra history flop.
module spi_slv_sync
   import spi_slv_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [SYNC_DEPTH:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {(SYNC_DEPTH + 1){RST_VAL}};
      end else begin
         chain <= {chain[SYNC_DEPTH-1:0], d};
      end
   end

   assign q    = chain[SYNC_DEPTH-1];
   assign rise = chain[SYNC_DEPTH-1] & ~chain[SYNC_DEPTH];
   assign fall = ~chain[SYNC_DEPTH-1] & chain[SYNC_DEPTH];

endmodule

// File: rtl/spi_slave_shift.sv
// SPI mode-0 slave shifter with tx holding register and rx valid/ready.
// Define SPI_SLV_OVR_EN to add the sticky ovr_o overrun flag.
module spi_slave_shift
   import spi_slv_pkg::*;
#(
   parameter int CHAR_LEN  = CHAR_LEN_DEF,
   parameter int LSB_FIRST = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sclk_pad_i,
   input  logic                ss_pad_i,
   input  logic                mosi_pad_i,
   output logic                miso_pad_o,
   output logic [CHAR_LEN-1:0] rx_data_o,
   output logic                rx_valid_o,
   input  logic                rx_ready_i,
   input  logic [CHAR_LEN-1:0] tx_data_i,
   input  logic                tx_load_i,
   output logic                busy_o
`ifdef SPI_SLV_OVR_EN
   ,
   output logic                ovr_o
`endif
);

   localparam int CW = $clog2(CHAR_LEN);

   function automatic logic out_bit(input logic [CHAR_LEN-1:0] v);
      return (LSB_FIRST != 0) ? v[0] : v[CHAR_LEN-1];
   endfunction

   logic sclk_q, sclk_rise, sclk_fall;
   logic ss_q, ss_rise, ss_fall;
   logic mosi_q, mosi_rise, mosi_fall;
   logic sync_unused;

   spi_slv_sync #(.RST_VAL(1'b0)) u_sclk (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (sclk_pad_i),
      .q    (sclk_q),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_slv_sync #(.RST_VAL(1'b1)) u_ss (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (ss_pad_i),
      .q    (ss_q),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   spi_slv_sync #(.RST_VAL(1'b0)) u_mosi (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (mosi_pad_i),
      .q    (mosi_q),
      .rise (mosi_rise),
      .fall (mosi_fall)
   );

   assign sync_unused = ^{sclk_q, ss_q, mosi_rise, mosi_fall};

   state_t state, state_nxt;
   logic   start, stop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      stop      = 1'b0;
      unique case (state)
         IDLE: begin
            if (ss_fall) begin
               state_nxt = ACTIVE;
               start     = 1'b1;
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_nxt = IDLE;
               stop      = 1'b1;
            end
         end
      endcase
   end

   assign busy_o = (state == ACTIVE);

   logic [CHAR_LEN-1:0] sr, sr_nxt, hold;
   logic [CW-1:0]       cnt;
   logic                reload;
   logic                last, shift_rise, shift_fall, done;

   // Deselect wins over a coincident sclk edge so a dying word never shifts.
   assign shift_rise = busy_o & sclk_rise & ~ss_rise;
   assign shift_fall = busy_o & sclk_fall & ~ss_rise;
   assign last       = (cnt == CW'(CHAR_LEN - 1));
   assign done       = shift_rise & last;
   assign sr_nxt     = (LSB_FIRST != 0) ? {mosi_q, sr[CHAR_LEN-1:1]}
                                        : {sr[CHAR_LEN-2:0], mosi_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold       <= '0;
         sr         <= '0;
         cnt        <= '0;
         reload     <= 1'b0;
         miso_pad_o <= 1'b0;
      end else begin
         if (tx_load_i) begin
            hold <= tx_data_i;
         end
         if (start) begin
            sr         <= hold;
            cnt        <= '0;
            reload     <= 1'b0;
            miso_pad_o <= out_bit(hold);
         end else if (stop) begin
            cnt    <= '0;
            reload <= 1'b0;
         end else begin
            if (shift_rise) begin
               sr  <= sr_nxt;
               cnt <= last ? '0 : cnt + 1'b1;
               if (last) begin
                  reload <= 1'b1;
               end
            end
            if (shift_fall) begin
               if (reload) begin
                  sr         <= hold;
                  reload     <= 1'b0;
                  miso_pad_o <= out_bit(hold);
               end else begin
                  miso_pad_o <= out_bit(sr);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_o  <= '0;
         rx_valid_o <= 1'b0;
      end else if (done && (!rx_valid_o || rx_ready_i)) begin
         rx_data_o  <= sr_nxt;
         rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
         rx_valid_o <= 1'b0;
      end
   end

`ifdef SPI_SLV_OVR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_o <= 1'b0;
      end else if (rx_valid_o && rx_ready_i) begin
         ovr_o <= 1'b0;
      end else if (done && rx_valid_o) begin
         ovr_o <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave_shift.sv
// Scoreboard bench for spi_slave_shift: an 8-bit MSB-first and a
// 16-bit LSB-first instance share sclk/mosi and have separate selects.
module tb_spi_slave_shift;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        sclk, mosi, ss_a, ss_b;
   logic        miso_a, miso_b;
   logic [7:0]  rx_data_a, tx_data_a;
   logic [15:0] rx_data_b, tx_data_b;
   logic        rx_valid_a, rx_valid_b;
   logic        tx_load_a, tx_load_b;
   logic        busy_a, busy_b;
   logic        man_a, auto_a, rnd_a, man_b;
   logic        rdy_a, rdy_b;
   logic [1:0]  rc = 2'd0;
`ifdef SPI_SLV_OVR_EN
   logic        ovr_a, ovr_b;
`endif

   assign rdy_a = auto_a ? rnd_a : man_a;
   assign rdy_b = man_b;

   always @(posedge clk) begin
      rc    <= rc + 2'd1;
      rnd_a <= (rc == 2'd0) | 1'($urandom_range(0, 1));
   end

   spi_slave_shift dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk_pad_i (sclk),
      .ss_pad_i   (ss_a),
      .mosi_pad_i (mosi),
      .miso_pad_o (miso_a),
      .rx_data_o  (rx_data_a),
      .rx_valid_o (rx_valid_a),
      .rx_ready_i (rdy_a),
      .tx_data_i  (tx_data_a),
      .tx_load_i  (tx_load_a),
      .busy_o     (busy_a)
`ifdef SPI_SLV_OVR_EN
      ,
      .ovr_o      (ovr_a)
`endif
   );

   spi_slave_shift #(.CHAR_LEN(16), .LSB_FIRST(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .sclk_pad_i (sclk),
      .ss_pad_i   (ss_b),
      .mosi_pad_i (mosi),
      .miso_pad_o (miso_b),
      .rx_data_o  (rx_data_b),
      .rx_valid_o (rx_valid_b),
      .rx_ready_i (rdy_b),
      .tx_data_i  (tx_data_b),
      .tx_load_i  (tx_load_b),
      .busy_o     (busy_b)
`ifdef SPI_SLV_OVR_EN
      ,
      .ovr_o      (ovr_b)
`endif
   );

   int          tests = 0;
   int          fails = 0;
   bit          done  = 1'b0;
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ss_set(input bit sel, input logic v);
      if (sel) ss_b = v;
      else     ss_a = v;
      wait_clk(6);
   endtask

   task automatic load(input bit sel, input logic [31:0] v);
      if (sel) begin
         tx_data_b = v[15:0];
         tx_load_b = 1'b1;
      end else begin
         tx_data_a = v[7:0];
         tx_load_a = 1'b1;
      end
      wait_clk(1);
      tx_load_a = 1'b0;
      tx_load_b = 1'b0;
   endtask

   // Mode-0 master: mosi set in the low phase, miso sampled before rising.
   task automatic spi_bits(input bit sel, input logic [31:0] mo,
                           input int len, input int n, input bit lsb,
                           input bit hs_last, output logic [31:0] mi);
      int idx;
      mi = '0;
      for (int i = 0; i < n; i++) begin
         idx  = lsb ? i : len - 1 - i;
         mosi = mo[idx];
         wait_clk(5);
         mi[idx] = sel ? miso_b : miso_a;
         sclk = 1'b1;
         if (hs_last && i == n - 1) begin
            @(posedge clk);
            @(posedge clk);
            #1 man_a = 1'b1;
            @(posedge clk);
            #1 man_a = 1'b0;
            chk("hs_valid", 32'(rx_valid_a), 32'd1);
            chk("hs_data", 32'(rx_data_a), mo & 32'hFF);
            wait_clk(2);
         end else begin
            wait_clk(5);
         end
         sclk = 1'b0;
         wait_clk(5);
      end
   endtask

   initial begin
      logic [31:0] mi, t, mo, exp, hold_m;
      bit          b2b;
      rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0;
      ss_a = 1'b1; ss_b = 1'b1;
      tx_data_a = '0; tx_data_b = '0;
      tx_load_a = 1'b0; tx_load_b = 1'b0;
      man_a = 1'b0; auto_a = 1'b0; man_b = 1'b1;
      fork
         begin
            wait_clk(3);
            chk("rst_valid_a", 32'(rx_valid_a), 32'd0);
            chk("rst_data_a", 32'(rx_data_a), 32'd0);
            chk("rst_miso_a", 32'(miso_a), 32'd0);
            chk("rst_busy_a", 32'(busy_a), 32'd0);
            chk("rst_valid_b", 32'(rx_valid_b), 32'd0);
            chk("rst_busy_b", 32'(busy_b), 32'd0);
`ifdef SPI_SLV_OVR_EN
            chk("rst_ovr_a", 32'(ovr_a), 32'd0);
`endif
            rst_n = 1'b1;
            wait_clk(3);

            // single word with one-cycle handshake
            man_a = 1'b1;
            load(0, 32'hA5);
            ss_set(0, 1'b0);
            chk("busy_on", 32'(busy_a), 32'd1);
            q_a.push_back(32'h3C);
            spi_bits(0, 32'h3C, 8, 8, 0, 0, mi);
            chk("miso_single", mi, 32'hA5);
            ss_set(0, 1'b1);
            chk("busy_off", 32'(busy_a), 32'd0);
            wait_clk(2);
            chk("valid_pulse", 32'(rx_valid_a), 32'd0);
            chk("q_single", 32'(q_a.size()), 32'd0);

            // back-to-back with consumer stalled: second word dropped
            man_a = 1'b0;
            load(0, 32'h5A);
            ss_set(0, 1'b0);
            load(0, 32'hC3);
            q_a.push_back(32'h11);
            spi_bits(0, 32'h11, 8, 8, 0, 0, mi);
            chk("miso_b2b_0", mi, 32'h5A);
            spi_bits(0, 32'h22, 8, 8, 0, 0, mi);
            chk("miso_b2b_1", mi, 32'hC3);
            chk("drop_data", 32'(rx_data_a), 32'h11);
            chk("drop_valid", 32'(rx_valid_a), 32'd1);
`ifdef SPI_SLV_OVR_EN
            chk("ovr_set", 32'(ovr_a), 32'd1);
`endif
            ss_set(0, 1'b1);
            man_a = 1'b1;
            wait_clk(2);
            chk("drop_cleared", 32'(rx_valid_a), 32'd0);
`ifdef SPI_SLV_OVR_EN
            chk("ovr_clr", 32'(ovr_a), 32'd0);
`endif

            // aborted partial word followed by a full word
            load(0, 32'h96);
            ss_set(0, 1'b0);
            spi_bits(0, 32'hFF, 8, 5, 0, 0, mi);
            ss_set(0, 1'b1);
            chk("abort_busy", 32'(busy_a), 32'd0);
            load(0, 32'h69);
            ss_set(0, 1'b0);
            q_a.push_back(32'h7E);
            spi_bits(0, 32'h7E, 8, 8, 0, 0, mi);
            chk("miso_abort", mi, 32'h69);
            ss_set(0, 1'b1);
            chk("q_abort", 32'(q_a.size()), 32'd0);

            // asynchronous reset mid-word
            load(0, 32'h3C);
            ss_set(0, 1'b0);
            spi_bits(0, 32'hF0, 8, 4, 0, 0, mi);
            #3 rst_n = 1'b0;
            #1;
            chk("arst_miso", 32'(miso_a), 32'd0);
            chk("arst_busy", 32'(busy_a), 32'd0);
            chk("arst_valid", 32'(rx_valid_a), 32'd0);
            chk("arst_data", 32'(rx_data_a), 32'd0);
            ss_a = 1'b1;
            wait_clk(3);
            rst_n = 1'b1;
            wait_clk(3);
            load(0, 32'hE7);
            ss_set(0, 1'b0);
            q_a.push_back(32'h81);
            spi_bits(0, 32'h81, 8, 8, 0, 0, mi);
            chk("miso_arst", mi, 32'hE7);
            ss_set(0, 1'b1);

            // word completes in the handshake cycle
            man_a = 1'b0;
            load(0, 32'h55);
            ss_set(0, 1'b0);
            q_a.push_back(32'hAB);
            q_a.push_back(32'hCD);
            spi_bits(0, 32'hAB, 8, 8, 0, 0, mi);
            chk("miso_hs_0", mi, 32'h55);
            spi_bits(0, 32'hCD, 8, 8, 0, 1, mi);
            chk("miso_hs_1", mi, 32'h55);
            ss_set(0, 1'b1);
            man_a = 1'b1;
            wait_clk(3);
            chk("q_hs", 32'(q_a.size()), 32'd0);

            // random words, random consumer, random back-to-back
            auto_a = 1'b1;
            hold_m = 32'h55;
            for (int k = 0; k < 16; k++) begin
               b2b = (ss_a == 1'b0) && ($urandom_range(0, 1) == 1);
               if (!b2b) begin
                  if (ss_a == 1'b0) ss_set(0, 1'b1);
                  t = $urandom & 32'hFF;
                  load(0, t);
                  hold_m = t;
                  ss_set(0, 1'b0);
               end
               exp = hold_m;
               if ($urandom_range(0, 1) == 1) begin
                  t = $urandom & 32'hFF;
                  load(0, t);
                  hold_m = t;
               end
               mo = $urandom & 32'hFF;
               q_a.push_back(mo);
               spi_bits(0, mo, 8, 8, 0, 0, mi);
               chk("miso_rand_a", mi, exp);
            end
            ss_set(0, 1'b1);
            wait_clk(4);
            auto_a = 1'b0;

            // 16-bit LSB-first instance
            load(1, 32'hBEEF);
            ss_set(1, 1'b0);
            q_b.push_back(32'h1234);
            spi_bits(1, 32'h1234, 16, 16, 1, 0, mi);
            chk("first_bit_lsb", 32'(mi[0]), 32'd1);
            chk("miso_lsb", mi, 32'hBEEF);
            ss_set(1, 1'b1);
            for (int k = 0; k < 3; k++) begin
               t = $urandom & 32'hFFFF;
               load(1, t);
               ss_set(1, 1'b0);
               mo = $urandom & 32'hFFFF;
               q_b.push_back(mo);
               spi_bits(1, mo, 16, 16, 1, 0, mi);
               chk("miso_rand_b", mi, t);
               ss_set(1, 1'b1);
            end
            wait_clk(5);
            chk("q_a_empty", 32'(q_a.size()), 32'd0);
            chk("q_b_empty", 32'(q_b.size()), 32'd0);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (rst_n) begin
                  if (rx_valid_a && rdy_a) begin
                     if (q_a.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_a: got %h expected no word",
                                 rx_data_a);
                     end else begin
                        chk("rx_a", 32'(rx_data_a), q_a.pop_front());
                     end
                  end
                  if (rx_valid_b && rdy_b) begin
                     if (q_b.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rx_b: got %h expected no word",
                                 rx_data_b);
                     end else begin
                        chk("rx_b", 32'(rx_data_b), q_b.pop_front());
                     end
                  end
               end
            end
         end
      join
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
